// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the memory bus arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_XFER  = 2'd2,
    ARB_TURN  = 2'd3
  } arb_state_e;

  // Width of a binary master index; a two-master bus still needs one bit.
  function automatic int arb_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = arb_idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               valid_o
);

  logic [IDW-1:0] cand;

  // Scan ptr+1, ptr+2 ... wrapping, and take the first active request.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin memory port arbiter with burst cap, lock and optional timeout (MEM_BUS_TIMEOUT_EN)
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 16,
  localparam int IDW = arb_idw(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  input  logic [NUM_REQ-1:0] rd_i,
  input  logic [NUM_REQ-1:0] wr_i,
  input  logic               mem_ready_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               mem_rd_o,
  output logic               mem_wr_o,
  output logic               busy_o,
  output logic               bus_err_o
);

  // Beat counter only needs to reach MAX_BURST; it parks there under lock.
  localparam int CNTW = $clog2(MAX_BURST + 1);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IDW-1:0]      gnt_id_q;
  logic [IDW-1:0]      ptr_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [CNTW-1:0]     cnt_q;
  logic [CNTW-1:0]     cnt_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDW-1:0]      pick_idx;
  logic                pick_valid;

  logic                own_req;
  logic                own_lock;
  logic                own_rd;
  logic                own_wr;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int WAITW = $clog2(TIMEOUT + 1);
  logic [WAITW-1:0]    wait_q;
  logic                bus_err_q;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Only the current owner's handshake lines are ever looked at.
  assign own_req  = req_i[gnt_id_q];
  assign own_lock = lock_i[gnt_id_q];
  assign own_rd   = rd_i[gnt_id_q];
  assign own_wr   = wr_i[gnt_id_q];

  // Beat count after the beat completing this cycle, held at MAX_BURST.
  assign cnt_d = (cnt_q == CNTW'(MAX_BURST)) ? cnt_q : cnt_q + 1'b1;

  // Arbitration FSM; every output it drives is a register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= IDW'(NUM_REQ - 1);
      ack_q     <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      cnt_q     <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      wait_q    <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_q    <= pick_gnt;
            gnt_id_q <= pick_idx;
            ptr_q    <= pick_idx;
            state_q  <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (own_rd || own_wr) begin
            // A simultaneous read and write strobe is treated as a write.
            mem_wr_q <= own_wr;
            mem_rd_q <= own_rd & ~own_wr;
            state_q  <= ARB_XFER;
`ifdef MEM_BUS_TIMEOUT_EN
            wait_q   <= '0;
`endif
          end else if (!own_req) begin
            gnt_q    <= '0;
            gnt_id_q <= '0;
            state_q  <= ARB_TURN;
          end
        end
        ARB_XFER: begin
          if (mem_ready_i) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            ack_q    <= gnt_q;
            cnt_q    <= cnt_d;
            if (own_req && (own_lock || (cnt_d < CNTW'(MAX_BURST)))) begin
              state_q <= ARB_GRANT;
            end else begin
              gnt_q    <= '0;
              gnt_id_q <= '0;
              state_q  <= ARB_TURN;
            end
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (wait_q == WAITW'(TIMEOUT - 1)) begin
            // Memory never answered: abandon the beat, no ack, lock ignored.
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            bus_err_q <= 1'b1;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            state_q   <= ARB_TURN;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        ARB_TURN: begin
          cnt_q   <= '0;
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = gnt_id_q;
  assign ack_o    = ack_q;
  assign mem_rd_o = mem_rd_q;
  assign mem_wr_o = mem_wr_q;
  assign busy_o   = (state_q != ARB_IDLE);

`ifdef MEM_BUS_TIMEOUT_EN
  assign bus_err_o = bus_err_q;
`else
  assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, lock, rd, wr;
  logic       rdy;
  logic [3:0] gnt, ack;
  logic [1:0] gnt_id;
  logic       mem_rd, mem_wr, busy, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_REQ   (4),
    .MAX_BURST (4),
    .TIMEOUT   (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .lock_i      (lock),
    .rd_i        (rd),
    .wr_i        (wr),
    .mem_ready_i (rdy),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .ack_o       (ack),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .busy_o      (busy),
    .bus_err_o   (bus_err)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] rd;
    logic [3:0] wr;
    logic       rdy;
    logic [3:0] e_gnt;
    logic [1:0] e_id;
    logic [3:0] e_ack;
    logic       e_mrd;
    logic       e_mwr;
    logic       e_busy;
  } vec_t;

  vec_t vec [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    req = '0; lock = '0; rd = '0; wr = '0; rdy = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int         acks;
  int         hold;
  int         lost;
  logic [1:0] e;
  logic [3:0] oh;

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; rd = '0; wr = '0; rdy = 1'b0;

    //            rst   req      lock     rd       wr       rdy    gnt      id     ack      mrd   mwr   busy
    vec[0]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b1};
    vec[3]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
    vec[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vec[5]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b1};
    vec[7]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vec[8]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vec[10] = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vec[11] = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b0, 1'b0, 1'b1};
    vec[12] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vec[13] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b1};
    vec[15] = '{1'b1, 4'b0100, 4'b0000, 4'b1100, 4'b0100, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1, 1'b1};
    vec[16] = '{1'b1, 4'b0100, 4'b0000, 4'b1100, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b0, 1'b0, 1'b1};
    vec[17] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vec[18] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};

    // Reset, single read, wait states, write-wins, ignored mem_ready.
    for (int i = 0; i < 19; i++) begin
      rst_n = vec[i].rst_n;
      req   = vec[i].req;
      lock  = vec[i].lock;
      rd    = vec[i].rd;
      wr    = vec[i].wr;
      rdy   = vec[i].rdy;
      tick();
      check($sformatf("v%0d_gnt", i),     32'(gnt),     32'(vec[i].e_gnt));
      check($sformatf("v%0d_gnt_id", i),  32'(gnt_id),  32'(vec[i].e_id));
      check($sformatf("v%0d_ack", i),     32'(ack),     32'(vec[i].e_ack));
      check($sformatf("v%0d_mem_rd", i),  32'(mem_rd),  32'(vec[i].e_mrd));
      check($sformatf("v%0d_mem_wr", i),  32'(mem_wr),  32'(vec[i].e_mwr));
      check($sformatf("v%0d_busy", i),    32'(busy),    32'(vec[i].e_busy));
      check($sformatf("v%0d_bus_err", i), 32'(bus_err), 32'd0);
    end

    // Fairness: all request, one read beat each, expect 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    rdy = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      e  = 2'(k % 4);
      oh = 4'b0001 << e;
      check($sformatf("fair%0d_gnt", k), 32'(gnt), 32'(oh));
      check($sformatf("fair%0d_id", k), 32'(gnt_id), 32'(e));
      rd[e] = 1'b1;
      tick();
      check($sformatf("fair%0d_mem_rd", k), 32'(mem_rd), 32'd1);
      tick();
      check($sformatf("fair%0d_ack", k), 32'(ack), 32'(oh));
      rd[e]  = 1'b0;
      req[e] = 1'b0;
      tick();
      check($sformatf("fair%0d_turn_gnt", k), 32'(gnt), 32'd0);
      check($sformatf("fair%0d_turn_busy", k), 32'(busy), 32'd1);
      req[e] = 1'b1;
      tick();
      check($sformatf("fair%0d_idle_busy", k), 32'(busy), 32'd0);
      tick();
    end

    // Burst cap: master 2 wants 5 write beats, master 3 waiting.
    do_reset();
    req = 4'b0100;
    tick();
    check("cap_first_gnt", 32'(gnt), 32'h4);
    req  = 4'b1100;
    wr   = 4'b0100;
    rdy  = 1'b1;
    acks = 0;
    hold = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (ack[2]) acks++;
      if (mem_wr) hold++;
    end
    check("cap_acks", 32'(acks), 32'd4);
    check("cap_wr_cycles", 32'(hold), 32'd4);
    check("cap_turn_gnt", 32'(gnt), 32'd0);
    check("cap_turn_busy", 32'(busy), 32'd1);
    wr = 4'b0000;
    tick();
    check("cap_idle_busy", 32'(busy), 32'd0);
    tick();
    check("cap_next_gnt", 32'(gnt), 32'h8);
    check("cap_next_id", 32'(gnt_id), 32'd3);

    // Same with lock: all five beats without losing the bus.
    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    tick();
    check("lock_first_gnt", 32'(gnt), 32'h4);
    req  = 4'b1100;
    wr   = 4'b0100;
    rdy  = 1'b1;
    acks = 0;
    lost = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (ack[2]) acks++;
      if (gnt != 4'b0100) lost++;
    end
    check("lock_acks", 32'(acks), 32'd5);
    check("lock_gnt_lost", 32'(lost), 32'd0);
    req  = 4'b1000;
    wr   = 4'b0000;
    lock = 4'b0000;
    tick();
    check("lock_release_gnt", 32'(gnt), 32'd0);
    tick();
    tick();
    check("lock_next_gnt", 32'(gnt), 32'h8);

`ifdef MEM_BUS_TIMEOUT_EN
    // Timeout: master 0 reads with lock held, memory never ready.
    do_reset();
    req  = 4'b0001;
    lock = 4'b0001;
    rd   = 4'b0001;
    rdy  = 1'b0;
    tick();
    tick();
    check("to_mem_rd_start", 32'(mem_rd), 32'd1);
    hold = 0;
    lost = 0;
    for (int t = 0; t < 7; t++) begin
      tick();
      if (mem_rd) hold++;
      if (bus_err) lost++;
    end
    check("to_wait_mem_rd", 32'(hold), 32'd7);
    check("to_early_bus_err", 32'(lost), 32'd0);
    tick();
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_mem_rd_drop", 32'(mem_rd), 32'd0);
    check("to_no_ack", 32'(ack), 32'd0);
    check("to_turn_gnt", 32'(gnt), 32'd0);
    check("to_turn_busy", 32'(busy), 32'd1);
    rd  = 4'b0000;
    req = 4'b0000;
    tick();
    check("to_bus_err_pulse", 32'(bus_err), 32'd0);
    check("to_idle_busy", 32'(busy), 32'd0);
`endif

    // Reset in the middle of a write beat.
    do_reset();
    req = 4'b0001;
    wr  = 4'b0001;
    rdy = 1'b0;
    tick();
    tick();
    check("rst_mid_mem_wr_before", 32'(mem_wr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_gnt", 32'(gnt), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    req = 4'b0110;
    wr  = 4'b0000;
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_after_gnt", 32'(gnt), 32'h2);
    check("rst_after_id", 32'(gnt_id), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
